wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the 8-bit pipelined core. Consumes the WB-side outputs of the MEM/WB pipeline register, selects the write-back value, and commits it to the register file on the clock edge. Provides the two ID-stage read ports with same-cycle write-through bypass, exports the selected write-back value for EX forwarding, and keeps a retire counter and an address-error flag.

## Interface
Parameters:
- NUM_REGS, 8, number of architectural registers; must be a power of two, 2..256
- CNT_W, 16, width of the retire counter

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- WB_mem_data  input  8  load data from MEM/WB
- WB_aluout  input  8  ALU result from MEM/WB
- WB_reg_write_addr  input  8  destination register index
- WB_RegWrite  input  1  write enable
- WB_MemtoReg  input  1  1 = write WB_mem_data, 0 = write WB_aluout
- ID_rs1_addr  input  8  read port 1 index
- ID_rs2_addr  input  8  read port 2 index
- ID_rs1_data  output  8  read port 1 data (combinational)
- ID_rs2_data  output  8  read port 2 data (combinational)
- WB_write_data  output  8  selected write-back value (combinational, for forwarding)
- WB_commit  output  1  registered; 1 for one cycle after each committed write
- retired_count  output  CNT_W  number of committed writes
- addr_err  output  1  sticky; set by an out-of-range write

## Operation
- WB_write_data = WB_MemtoReg ? WB_mem_data : WB_aluout, at all times, regardless of WB_RegWrite.
- Index width AW = log2(NUM_REGS). An index is in range iff bits [7:AW] are zero.
- R0 is hardwired to 0x00. Writes to R0 are discarded without error. Reads of R0 return 0x00.
- Commit condition: WB_RegWrite=1, index in range, index≠0. On a rising edge with the commit condition true and rst_n=1: reg[index] ← WB_write_data, retired_count += 1, WB_commit ← 1. Otherwise WB_commit ← 0.
- Out-of-range write with WB_RegWrite=1: no register change, no count, addr_err ← 1. addr_err stays set until reset.
- retired_count wraps from 2^CNT_W−1 to 0 silently.
- Read port n:
  - index out of range → 0x00.
  - index = 0 → 0x00.
  - index equals the current commit index with the commit condition true → WB_write_data (bypass).
  - otherwise → reg[index].
- Both ports may read the same register. Both may bypass in the same cycle.

## Timing
- Reset (rst_n=0 at an edge): all registers become 0x00, retired_count=0, WB_commit=0, addr_err=0. The write inputs are ignored that cycle. Reset has priority over a simultaneous commit.
- Write latency: 1 edge. The value is visible from storage on the cycle after the edge, and visible the same cycle through the bypass.
- Read ports and WB_write_data are purely combinational: zero latency, no clock dependence.
- There is no handshake and no stall: the block accepts one write per cycle, every cycle.
- A back-to-back write to the same register: the later write wins, and each write counts.

## Structure
- Shared package cpu_pkg holds DATA_W=8, REG_IDX_W=8, and the function that computes the range check and index truncation. The MEM/WB register uses the same package widths.
- Sub-module regfile_core holds the storage array with one synchronous write port, two asynchronous read ports, R0 forced to zero, and reset clearing. It has no bypass.
- The wb_regfile top contains the write-back mux, the range check, the bypass muxes, the counter, WB_commit, and addr_err.

## Test plan
- Reset, then read all indices 0..7 on both ports → all 0x00; retired_count=0; addr_err=0.
- Write R3 with WB_MemtoReg=0, aluout=0x5A, mem_data=0xC3 while ID_rs1_addr=3 → ID_rs1_data=0x5A the same cycle (bypass); after the edge, stored value 0x5A, WB_commit=1 for one cycle, retired_count=1.
- Write R3 with WB_MemtoReg=1, mem_data=0xC3 → WB_write_data=0xC3; R3=0xC3 afterwards. Then write R0 with 0xFF → R0 reads 0x00, retired_count unchanged, addr_err=0.
- Write index 0x08 with RegWrite=1 → no register changes, addr_err=1 and it stays set; reading index 0x08 returns 0x00.
- Issue 2^CNT_W commits (run with CNT_W=4 for 16 commits) → retired_count wraps to 0.
- Assert rst_n=0 in the same cycle as a commit to R5 with 0x77 → R5=0x00, retired_count=0, WB_commit=0 after the edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths for the 8-bit core pipeline and the register index range check.
package cpu_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_IDX_W = 8;

    typedef struct packed {
        logic                 ok;
        logic [REG_IDX_W-1:0] idx;
    } reg_idx_t;

    // ok is set when no bits above the low aw bits are set; idx keeps only the low aw bits.
    function automatic reg_idx_t idx_check(input logic [REG_IDX_W-1:0] raw, input int aw);
        reg_idx_t             r;
        logic [REG_IDX_W:0]   mask;
        mask  = (9'd1 << aw) - 9'd1;
        r.ok  = ((raw >> aw) == '0);
        r.idx = raw & mask[REG_IDX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/regfile_core.sv
// Register storage: one synchronous write port, two asynchronous read ports, R0 reads as zero.
module regfile_core
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr1_i,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, range check, commit bookkeeping and ID read-port bypass.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    WB_mem_data,
    input  logic [DATA_W-1:0]    WB_aluout,
    input  logic [REG_IDX_W-1:0] WB_reg_write_addr,
    input  logic                 WB_RegWrite,
    input  logic                 WB_MemtoReg,
    input  logic [REG_IDX_W-1:0] ID_rs1_addr,
    input  logic [REG_IDX_W-1:0] ID_rs2_addr,
    output logic [DATA_W-1:0]    ID_rs1_data,
    output logic [DATA_W-1:0]    ID_rs2_data,
    output logic [DATA_W-1:0]    WB_write_data,
    output logic                 WB_commit,
    output logic [CNT_W-1:0]     retired_count,
    output logic                 addr_err
);

    localparam int AW = $clog2(NUM_REGS);

    reg_idx_t          wr, rd1, rd2;
    logic              commit;
    logic [DATA_W-1:0] core_rd1, core_rd2;

    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              commit_q, commit_d;
    logic              addr_err_q, addr_err_d;

    assign WB_write_data = WB_MemtoReg ? WB_mem_data : WB_aluout;

    assign wr  = idx_check(WB_reg_write_addr, AW);
    assign rd1 = idx_check(ID_rs1_addr, AW);
    assign rd2 = idx_check(ID_rs2_addr, AW);

    // Writes aimed at R0 are dropped silently; only out-of-range targets raise addr_err.
    assign commit = WB_RegWrite && wr.ok && (wr.idx != '0);

    regfile_core #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (commit),
        .waddr_i  (wr.idx[AW-1:0]),
        .wdata_i  (WB_write_data),
        .raddr1_i (rd1.idx[AW-1:0]),
        .raddr2_i (rd2.idx[AW-1:0]),
        .rdata1_o (core_rd1),
        .rdata2_o (core_rd2)
    );

    always_comb begin
        ID_rs1_data = core_rd1;
        if (!rd1.ok || (rd1.idx == '0)) begin
            ID_rs1_data = '0;
        end else if (commit && (rd1.idx == wr.idx)) begin
            ID_rs1_data = WB_write_data;
        end
    end

    always_comb begin
        ID_rs2_data = core_rd2;
        if (!rd2.ok || (rd2.idx == '0)) begin
            ID_rs2_data = '0;
        end else if (commit && (rd2.idx == wr.idx)) begin
            ID_rs2_data = WB_write_data;
        end
    end

    always_comb begin
        retired_d  = commit ? retired_q + CNT_W'(1) : retired_q;
        commit_d   = commit;
        addr_err_d = addr_err_q | (WB_RegWrite & ~wr.ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q  <= '0;
            commit_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            retired_q  <= retired_d;
            commit_q   <= commit_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign retired_count = retired_q;
    assign WB_commit     = commit_q;
    assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile (8 registers, 4-bit retire counter to exercise the wrap).
module tb_wb_regfile;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] WB_mem_data, WB_aluout, WB_reg_write_addr;
    logic       WB_RegWrite, WB_MemtoReg;
    logic [7:0] ID_rs1_addr, ID_rs2_addr;
    logic [7:0] ID_rs1_data, ID_rs2_data, WB_write_data;
    logic       WB_commit;
    logic [3:0] retired_count;
    logic       addr_err;

    int vecs = 0;
    int errs = 0;

    wb_regfile #(.NUM_REGS(8), .CNT_W(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .WB_mem_data       (WB_mem_data),
        .WB_aluout         (WB_aluout),
        .WB_reg_write_addr (WB_reg_write_addr),
        .WB_RegWrite       (WB_RegWrite),
        .WB_MemtoReg       (WB_MemtoReg),
        .ID_rs1_addr       (ID_rs1_addr),
        .ID_rs2_addr       (ID_rs2_addr),
        .ID_rs1_data       (ID_rs1_data),
        .ID_rs2_data       (ID_rs2_data),
        .WB_write_data     (WB_write_data),
        .WB_commit         (WB_commit),
        .retired_count     (retired_count),
        .addr_err          (addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [7:0] addr,
                         input logic [7:0] alu, input logic [7:0] mem,
                         input logic [7:0] r1, input logic [7:0] r2);
        @(negedge clk);
        WB_RegWrite       = we;
        WB_MemtoReg       = m2r;
        WB_reg_write_addr = addr;
        WB_aluout         = alu;
        WB_mem_data       = mem;
        ID_rs1_addr       = r1;
        ID_rs2_addr       = r2;
        #1;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        WB_RegWrite = 0; WB_MemtoReg = 0; WB_reg_write_addr = 0;
        WB_aluout = 0; WB_mem_data = 0; ID_rs1_addr = 0; ID_rs2_addr = 0;
        edge_sample();
        edge_sample();
        rst_n = 1'b1;

        // reset state on every index
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 8'd0, 8'h00, 8'h00, 8'(i), 8'(7 - i));
            chk("rst_rs1", {8'h0, ID_rs1_data}, 16'h0000);
            chk("rst_rs2", {8'h0, ID_rs2_data}, 16'h0000);
        end
        chk("rst_retired", {12'h0, retired_count}, 16'h0000);
        chk("rst_addr_err", {15'h0, addr_err}, 16'h0000);
        chk("rst_commit", {15'h0, WB_commit}, 16'h0000);

        // R3 <= aluout 0x5A, bypass on rs1
        drive(1, 0, 8'd3, 8'h5A, 8'hC3, 8'd3, 8'd4);
        chk("wbdata_alu", {8'h0, WB_write_data}, 16'h005A);
        chk("bypass_rs1", {8'h0, ID_rs1_data}, 16'h005A);
        chk("rs2_r4_zero", {8'h0, ID_rs2_data}, 16'h0000);
        edge_sample();
        chk("commit_r3", {15'h0, WB_commit}, 16'h0001);
        chk("retired_1", {12'h0, retired_count}, 16'h0001);
        drive(0, 0, 8'd3, 8'h00, 8'h00, 8'd3, 8'd0);
        chk("stored_r3", {8'h0, ID_rs1_data}, 16'h005A);
        edge_sample();
        chk("commit_pulse_end", {15'h0, WB_commit}, 16'h0000);

        // R3 <= mem_data 0xC3, both ports bypass
        drive(1, 1, 8'd3, 8'h5A, 8'hC3, 8'd3, 8'd3);
        chk("wbdata_mem", {8'h0, WB_write_data}, 16'h00C3);
        chk("bypass_both1", {8'h0, ID_rs1_data}, 16'h00C3);
        chk("bypass_both2", {8'h0, ID_rs2_data}, 16'h00C3);
        edge_sample();
        chk("retired_2", {12'h0, retired_count}, 16'h0002);

        // write to R0 is discarded
        drive(1, 0, 8'd0, 8'hFF, 8'h00, 8'd0, 8'd3);
        chk("r0_read", {8'h0, ID_rs1_data}, 16'h0000);
        chk("r3_after_mem", {8'h0, ID_rs2_data}, 16'h00C3);
        edge_sample();
        chk("r0_no_commit", {15'h0, WB_commit}, 16'h0000);
        chk("r0_no_count", {12'h0, retired_count}, 16'h0002);
        chk("r0_no_err", {15'h0, addr_err}, 16'h0000);
        drive(0, 0, 8'd0, 8'h00, 8'h00, 8'd0, 8'd0);
        chk("r0_still_zero", {8'h0, ID_rs1_data}, 16'h0000);

        // out-of-range write to index 8
        drive(1, 0, 8'd8, 8'h11, 8'h22, 8'd8, 8'd3);
        chk("oor_read", {8'h0, ID_rs1_data}, 16'h0000);
        chk("oor_r3_kept", {8'h0, ID_rs2_data}, 16'h00C3);
        edge_sample();
        chk("oor_err_set", {15'h0, addr_err}, 16'h0001);
        chk("oor_no_count", {12'h0, retired_count}, 16'h0002);
        chk("oor_no_commit", {15'h0, WB_commit}, 16'h0000);
        drive(0, 0, 8'd0, 8'h00, 8'h00, 8'd3, 8'd0);
        chk("oor_r3_after", {8'h0, ID_rs1_data}, 16'h00C3);
        edge_sample();
        chk("err_sticky", {15'h0, addr_err}, 16'h0001);

        // back-to-back writes to R2; counter reaches 15 then wraps to 0
        for (int i = 1; i <= 13; i++) begin
            drive(1, 0, 8'd2, 8'(i), 8'h00, 8'd2, 8'd0);
            edge_sample();
        end
        chk("retired_15", {12'h0, retired_count}, 16'h000F);
        drive(1, 0, 8'd2, 8'h0E, 8'h00, 8'd2, 8'd0);
        edge_sample();
        chk("retired_wrap", {12'h0, retired_count}, 16'h0000);
        chk("wrap_commit", {15'h0, WB_commit}, 16'h0001);
        drive(0, 0, 8'd0, 8'h00, 8'h00, 8'd2, 8'd0);
        chk("r2_last_wins", {8'h0, ID_rs1_data}, 16'h000E);

        // reset beats a simultaneous commit to R5
        drive(1, 0, 8'd5, 8'h77, 8'h00, 8'd5, 8'd2);
        rst_n = 1'b0;
        edge_sample();
        chk("rst_commit_flag", {15'h0, WB_commit}, 16'h0000);
        chk("rst_count_clear", {12'h0, retired_count}, 16'h0000);
        chk("rst_err_clear", {15'h0, addr_err}, 16'h0000);
        drive(0, 0, 8'd0, 8'h00, 8'h00, 8'd5, 8'd2);
        rst_n = 1'b1;
        #1;
        chk("rst_r5_zero", {8'h0, ID_rs1_data}, 16'h0000);
        chk("rst_r2_zero", {8'h0, ID_rs2_data}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
